regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write bypass and per-register pending-write scoreboard
module regfile_scoreboard #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter int              AW      = $clog2(NREGS),
  parameter int              NRD     = 2,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy_vec
);

  // Register 0 is hardwired to zero, so storage starts at index 1.
  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [XLEN-1:0]  regs_d [1:NREGS-1];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Port 1 is applied after port 0 so it wins a same-address write;
  // the issue is applied last so a new producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (we0 && (waddr0 == AW'(r))) begin
        regs_d[r] = wdata0;
        busy_d[r] = 1'b0;
      end
      if (we1 && (waddr1 == AW'(r))) begin
        regs_d[r] = wdata1;
        busy_d[r] = 1'b0;
      end
      if (iss_valid && (iss_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // Addresses of 0 or >= NREGS never produce a hit, so they read 0 and not busy.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] stored;
    logic [XLEN-1:0] data;
    logic            hit;
    logic            busy_hit;
    logic            wr1_hit;
    logic            wr0_hit;
    logic            busy_out;

    assign a       = raddr[i*AW +: AW];
    assign wr1_hit = we1 && (waddr1 == a);
    assign wr0_hit = we0 && (waddr0 == a);

    always_comb begin
      stored   = '0;
      hit      = 1'b0;
      busy_hit = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (a == AW'(r)) begin
          hit      = 1'b1;
          stored   = regs_q[r];
          busy_hit = busy_q[r];
        end
      end
    end

    always_comb begin
      data     = '0;
      busy_out = 1'b0;
      if (hit) begin
        if (wr1_hit) begin
          data = wdata1;
        end else if (wr0_hit) begin
          data = wdata0;
        end else begin
          data = stored;
        end
        busy_out = busy_hit && !wr1_hit && !wr0_hit;
      end
    end

    assign rdata[i*XLEN +: XLEN] = data;
    assign rbusy[i]              = busy_out;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy_vec;

  regfile_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_RD0 = 0, K_RD1 = 1, K_RBUSY = 2, K_BUSY = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] act;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected values are checked mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        K_RD0:   act = rdata[31:0];
        K_RD1:   act = rdata[63:32];
        K_RBUSY: act = {30'd0, rbusy};
        default: act = busy_vec;
      endcase
      checks++;
      if (act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h (cycle %0d)", mon_e.name, act, mon_e.exp, cyc);
      end
    end
  end

  task automatic push_exp(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    we0       = 1'b0;
    we1       = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_valid = 1'b1; iss_addr = a;
  endtask

  initial begin
    reset = 1'b1; raddr = '0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    iss_valid = 1'b0; iss_addr = '0;

    next_cycle(); reset = 1'b1;
    next_cycle(); rd(5'd0, 5'd2);
    push_exp("reset_r0", K_RD0, 32'h0);
    push_exp("reset_r2", K_RD1, 32'h200);
    push_exp("reset_busy", K_BUSY, 32'h0);
    push_exp("reset_rbusy", K_RBUSY, 32'h0);
    next_cycle(); rd(5'd5, 5'd2);
    push_exp("reset_r5", K_RD0, 32'h0);

    next_cycle(); rd(5'd7, 5'd9); wr0(5'd7, 32'hDEADBEEF);
    push_exp("bypass_w0_r7", K_RD0, 32'hDEADBEEF);
    push_exp("unwritten_r9", K_RD1, 32'h0);
    next_cycle(); rd(5'd7, 5'd9);
    push_exp("stored_r7", K_RD0, 32'hDEADBEEF);

    next_cycle(); rd(5'd9, 5'd7); wr0(5'd9, 32'h1); wr1(5'd9, 32'h2);
    push_exp("prio_bypass_r9", K_RD0, 32'h2);
    next_cycle(); rd(5'd9, 5'd7);
    push_exp("prio_stored_r9", K_RD0, 32'h2);

    next_cycle(); rd(5'd0, 5'd4); iss(5'd4);
    push_exp("issue_not_yet_busy", K_BUSY, 32'h0);
    next_cycle(); rd(5'd0, 5'd4);
    push_exp("busy4_set", K_BUSY, 32'h10);
    push_exp("rbusy1_r4", K_RBUSY, 32'h2);
    next_cycle(); rd(5'd0, 5'd4); wr1(5'd4, 32'h44);
    push_exp("rbusy_masked_by_write", K_RBUSY, 32'h0);
    push_exp("bypass_w1_r4", K_RD1, 32'h44);
    push_exp("busy4_still_reg", K_BUSY, 32'h10);
    next_cycle(); rd(5'd0, 5'd4);
    push_exp("busy4_cleared", K_BUSY, 32'h0);
    push_exp("stored_r4", K_RD1, 32'h44);

    next_cycle(); rd(5'd6, 5'd4); iss(5'd6); wr0(5'd6, 32'h66);
    push_exp("bypass_r6", K_RD0, 32'h66);
    next_cycle(); rd(5'd6, 5'd4);
    push_exp("issue_beats_write_r6", K_BUSY, 32'h40);
    push_exp("rbusy0_r6", K_RBUSY, 32'h1);
    push_exp("stored_r6", K_RD0, 32'h66);

    next_cycle(); rd(5'd0, 5'd4); wr1(5'd0, 32'hFFFF_FFFF); iss(5'd0);
    push_exp("r0_no_bypass", K_RD0, 32'h0);
    next_cycle(); rd(5'd0, 5'd4);
    push_exp("r0_stays_zero", K_RD0, 32'h0);
    push_exp("r0_never_busy", K_BUSY, 32'h40);

    next_cycle(); rd(5'd2, 5'd8); iss(5'd3); wr1(5'd2, 32'h22);
    next_cycle(); rd(5'd2, 5'd8); iss(5'd8);
    next_cycle(); rd(5'd2, 5'd8);
    push_exp("stored_r2", K_RD0, 32'h22);
    push_exp("busy_3_6_8", K_BUSY, 32'h148);
    push_exp("rbusy1_r8", K_RBUSY, 32'h2);

    next_cycle(); rd(5'd2, 5'd5); reset = 1'b1; wr0(5'd2, 32'h99); iss(5'd5);
    next_cycle(); rd(5'd2, 5'd5);
    push_exp("midreset_r2", K_RD0, 32'h200);
    push_exp("midreset_r5", K_RD1, 32'h0);
    push_exp("midreset_busy", K_BUSY, 32'h0);
    push_exp("midreset_rbusy", K_RBUSY, 32'h0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
